// File: rtl/tanh_forward_pkg.sv
// Shared constants, FSM encoding and layer-base helper for the tanh forward stage.
package tanh_forward_pkg;

  localparam int HID_DIM   = 16;
  localparam int DATA_N    = 8;
  localparam int N_LEN     = 16;
  localparam int STATE_LEN = 4;

  localparam logic [STATE_LEN-1:0] F_MIX1 = 4'd1;
  localparam logic [STATE_LEN-1:0] F_MIX2 = 4'd2;
  localparam logic [STATE_LEN-1:0] F_MIX3 = 4'd3;

  localparam int CHUNKS  = HID_DIM / DATA_N;
  localparam int CHUNK_W = DATA_N * N_LEN;
  localparam int VEC_W   = HID_DIM * N_LEN;
  localparam int CNT_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Start of the z-buffer region owned by a layer; non-mix states map to 0.
  function automatic int layer_base(input logic [STATE_LEN-1:0] st, input int rows);
    int layer;
    case (st)
      F_MIX2:  layer = 1;
      F_MIX3:  layer = 2;
      default: layer = 0;
    endcase
    return layer * rows * CHUNKS;
  endfunction

endpackage

// File: rtl/tanh_forward_if.sv
// Handshake and z-buffer write bus of the tanh forward stage.
interface tanh_forward_if
  import tanh_forward_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) ();

  logic                  run;
  logic [STATE_LEN-1:0]  state;
  logic                  d_valid;
  logic [VEC_W-1:0]      d;
  logic                  valid;
  logic                  busy;
  logic [VEC_W-1:0]      q;
  logic                  we_z;
  logic [ADDR_WIDTH-1:0] waddr_z;
  logic [CHUNK_W-1:0]    wdata_z;
  logic                  err_overrun;

  modport master (
    output run, state, d_valid, d,
    input  valid, busy, q, we_z, waddr_z, wdata_z, err_overrun
  );

  modport slave (
    input  run, state, d_valid, d,
    output valid, busy, q, we_z, waddr_z, wdata_z, err_overrun
  );

endinterface

// File: rtl/tanh_forward_tanh_pla.sv
// Shift-only piecewise-linear tanh for one signed fixed-point element.
module tanh_pla #(
  parameter int N_LEN     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic [N_LEN-1:0] x_i,
  output logic [N_LEN-1:0] y_o
);

  localparam logic [N_LEN:0]   HALF_W       = (N_LEN+1)'(1) << (FRAC_BITS-1);
  localparam logic [N_LEN:0]   THREE_HALF_W = (N_LEN+1)'(3) << (FRAC_BITS-1);
  localparam logic [N_LEN-1:0] ONE_N        = N_LEN'(1) << FRAC_BITS;
  localparam logic [N_LEN-1:0] QUARTER_N    = N_LEN'(1) << (FRAC_BITS-2);

  logic             neg;
  logic [N_LEN:0]   xe;
  logic [N_LEN:0]   a;
  logic [N_LEN-1:0] y;

  // Magnitude is taken one bit wider so the most negative input saturates cleanly.
  always_comb begin
    neg = x_i[N_LEN-1];
    xe  = {x_i[N_LEN-1], x_i};
    a   = neg ? (~xe + (N_LEN+1)'(1)) : xe;
    if (a < HALF_W) begin
      y = a[N_LEN-1:0];
    end else if (a < THREE_HALF_W) begin
      y = QUARTER_N + a[N_LEN:1];
    end else begin
      y = ONE_N;
    end
    y_o = neg ? (~y + N_LEN'(1)) : y;
  end

endmodule

// File: rtl/tanh_forward.sv
// tanh activation stage: latches a pre-activation vector, activates it chunk by
// chunk, mirrors each raw chunk into the z buffer and pulses valid when done.
//
//   state | meaning
//   IDLE  | waiting for run & d_valid
//   CALC  | one chunk per cycle: activate into q, write raw chunk to z buffer
//   DONE  | valid pulse; may accept the next vector immediately
module tanh_forward
  import tanh_forward_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int FRAC_BITS  = 8,
  parameter int ROWS       = 16
) (
  input  logic          clk,
  input  logic          rst,
  tanh_forward_if.slave bus
);

  fsm_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [VEC_W-1:0]      lat_q, lat_d;
  logic [VEC_W-1:0]      q_q, q_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CHUNK_W-1:0]    raw_chunk;
  logic [CHUNK_W-1:0]    act_chunk;

  assign base_addr = ADDR_WIDTH'(layer_base(bus.state, ROWS));

  // Select the chunk of the latched vector addressed by the chunk counter.
  always_comb begin
    raw_chunk = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        raw_chunk = lat_q[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  for (genvar i = 0; i < DATA_N; i++) begin : g_pla
    tanh_pla #(
      .N_LEN     (N_LEN),
      .FRAC_BITS (FRAC_BITS)
    ) u_pla (
      .x_i (raw_chunk[i*N_LEN +: N_LEN]),
      .y_o (act_chunk[i*N_LEN +: N_LEN])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latched input, result, chunk counter, write pointer, error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lat_q <= '0;
      q_q   <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      q_q   <= q_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // Next-state and datapath update; run low overrides counters, pointer and flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    q_d     = q_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run && bus.d_valid) begin
          state_d = ST_CALC;
          lat_d   = bus.d;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        for (int k = 0; k < CHUNKS; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            q_d[k*CHUNK_W +: CHUNK_W] = act_chunk;
          end
        end
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (bus.d_valid) begin
          err_d = 1'b1;
        end
        if (cnt_q == CNT_W'(CHUNKS-1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.run && bus.d_valid) begin
          state_d = ST_CALC;
          lat_d   = bus.d;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (!bus.run) begin
      cnt_d = '0;
      ptr_d = base_addr;
      err_d = 1'b0;
      if (state_q == ST_CALC) begin
        state_d = ST_IDLE;
      end
    end
  end

  assign bus.valid       = (state_q == ST_DONE);
  assign bus.busy        = (state_q == ST_CALC);
  assign bus.we_z        = (state_q == ST_CALC);
  assign bus.waddr_z     = ptr_q;
  assign bus.wdata_z     = (state_q == ST_CALC) ? raw_chunk : '0;
  assign bus.q           = q_q;
  assign bus.err_overrun = err_q;

endmodule

// File: doc/tanh_forward.md
Name: tanh_forward

Overview:
- Activation stage directly downstream of the mix-layer forward dot product.
- Accepts one HID_DIM-wide pre-activation vector per pulse and applies a shift-only piecewise-linear tanh, DATA_N elements per cycle.
- Returns the full activated vector with a one-cycle valid pulse.
- Writes each pre-activation chunk into the backward-pass buffer (z RAM), so the mix backward stage can recompute the derivative.

Parameters:
- ADDR_WIDTH, 9, width of z-buffer write address.
- FRAC_BITS, 8, fractional bits of the signed `N_LEN fixed-point format.
- ROWS, 16, vectors per layer pass; sets the per-layer z-buffer region size.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  layer-pass enable. Low clears counters and reloads the address base.
- state  in  `STATE_LEN  current layer (`F_MIX1/`F_MIX2/`F_MIX3); selects the z-buffer region.
- d_valid  in  1  one-cycle pulse; d holds a valid pre-activation vector.
- d  in  `HID_DIM*`N_LEN  pre-activation vector, element i at [i*`N_LEN +: `N_LEN].
- valid  out  1  one-cycle pulse; q holds the completed activated vector.
- busy  out  1  high while in CALC.
- q  out  `HID_DIM*`N_LEN  activated vector; held until overwritten.
- we_z  out  1  z-buffer write enable.
- waddr_z  out  ADDR_WIDTH  z-buffer write address.
- wdata_z  out  `DATA_N*`N_LEN  pre-activation chunk written to the z buffer.
- err_overrun  out  1  sticky; set when d_valid arrives during CALC.

Behaviour:
- Reset values: all outputs and internal state are 0, and the FSM is in IDLE.
- CHUNKS = `HID_DIM/`DATA_N, which is an integer by construction.
- FSM states: IDLE, CALC, DONE.
- IDLE → CALC on run & d_valid. On that edge, latch d into the input register and set chunk counter = 0.
- CALC, per cycle:
  - Process chunk[cnt] = latched[cnt*`DATA_N*`N_LEN +: `DATA_N*`N_LEN].
  - Register the activated chunk into q at the same slice.
  - Assert we_z=1, wdata_z=raw chunk, waddr_z=current pointer.
  - Increment cnt and the pointer.
  - After cnt==CHUNKS-1, go to DONE.
- DONE: valid=1 for exactly one cycle. If d_valid is present, latch it and go to CALC; otherwise go to IDLE.
- d_valid in CALC is dropped (the latched vector is not disturbed) and sets err_overrun.
- Latency: d_valid in cycle T gives we_z in T+1..T+CHUNKS and valid in T+CHUNKS+1. Back-to-back throughput is one vector per CHUNKS+1 cycles.
- Activation, per element x (signed `N_LEN, Q(FRAC_BITS)), with a = |x|, ONE = 1<<FRAC_BITS, HALF = ONE>>1:
  - a < HALF: y = a.
  - HALF <= a < 3*HALF: y = (ONE>>2) + (a>>>1).
  - a >= 3*HALF: y = ONE.
  - Output is sign(x)*y. The curve is continuous at the breakpoints.
  - For the most negative x, take a at full width (one extra bit) so it saturates to -ONE.
- Write pointer:
  - When run=0, the pointer loads base(state) = layer*ROWS*CHUNKS with layer 0/1/2 for F_MIX1/2/3. Other states give base 0.
  - Under run it increments per written chunk and wraps modulo 2^ADDR_WIDTH.
- run low mid-CALC: abort next cycle to IDLE. No valid, no further we_z, and q keeps its partial contents.
- err_overrun clears only on rst or run=0.
- The rst assertion at any time forces the reset values immediately.

Decomposition:
- Shared consts header (already included by the train blocks) provides `HID_DIM, `DATA_N, `N_LEN, `STATE_LEN, `F_MIX1..3.
- Add `CHUNKS and the FSM state encodings there.
- One natural sub-module: tanh_pla, purely combinational, one element, parameterised by `N_LEN/FRAC_BITS. It is instantiated `DATA_N times via generate.

Test Plan (`DATA_N=8, `HID_DIM=16, `N_LEN=16, FRAC_BITS=8, so CHUNKS=2):
- Element values:
  - 0x0040 (0.25) → 0x0040.
  - 0x0100 (1.0) → 0x00C0.
  - 0x0180 → 0x0100.
  - 0x7FFF → 0x0100.
  - 0xFF00 (-1.0) → 0xFF40.
  - 0x8000 → 0xFF00.
- Single vector, state=`F_MIX2, run held, d_valid at T:
  - we_z at T+1 with waddr_z=32 and T+2 with waddr_z=33.
  - wdata_z equals the raw chunks.
  - valid at T+3 only; q matches the golden model.
- Back-to-back: d_valid at T and at T+3:
  - Second vector accepted without err.
  - valid at T+3 and T+6.
  - waddr_z sequence 0,1,2,3 under `F_MIX1.
- Overrun: d_valid at T and T+1:
  - err_overrun=1 from T+2.
  - Output is from the first vector only.
  - Flag clears after run=0.
- Abort: run dropped at T+1:
  - No valid, and we_z low from T+2.
  - Next pass restarts at base(state).
- Reset mid-CALC: rst at T+1 immediately zeroes valid, we_z, q, busy and err_overrun.
